// File: rtl/uart_tx_frame.sv
// UART transmitter: serialises a byte as start bit, LSB-first data bits,
// optional parity bit and one stop bit, each held for Prescale clocks.
// TX_OUT and busy are registered, so neither has a combinational input path.
module uart_tx_frame #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      Data_Valid,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic                      TX_OUT,
  output logic                      busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0]          LAST_IDX = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0]          IDX_ONE  = IDX_W'(1);
  localparam logic [PRESCALE_WIDTH-1:0] CNT_ONE  = PRESCALE_WIDTH'(1);
  localparam logic [PRESCALE_WIDTH-1:0] MIN_P    = PRESCALE_WIDTH'(4);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                    state, state_nxt;
  logic [PRESCALE_WIDTH-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0]          idx, idx_nxt;
  logic [PRESCALE_WIDTH-1:0] presc_q;
  logic [DATA_WIDTH-1:0]     data_q;
  logic                      par_en_q;
  logic                      par_typ_q;
  logic                      accept;
  logic                      bit_done;
  logic                      tx_nxt;
  logic                      busy_nxt;

  // Parity of the latched byte; odd parity is the inverted even result.
  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d,
                                      input logic odd);
    return (^d) ^ odd;
  endfunction

  // Last clock of the current bit period.
  assign bit_done = (cnt == (presc_q - CNT_ONE));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state, bit counters and the value the line takes next cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (Data_Valid) begin
          accept    = 1'b1;
          state_nxt = START;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
      end
      START: begin
        if (bit_done) begin
          state_nxt = DATA;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_nxt = '0;
          if (idx == LAST_IDX) begin
            idx_nxt   = '0;
            state_nxt = par_en_q ? PARITY : STOP;
          end else begin
            idx_nxt = idx + IDX_ONE;
          end
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_nxt = STOP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      STOP: begin
        if (bit_done) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
    endcase

    // The data/parity bits are only reached after the shadow regs are loaded.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = data_q[idx_nxt];
      PARITY:  tx_nxt = parity_bit(data_q, par_typ_q);
      default: tx_nxt = 1'b1;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // Bit timing counters and registered line/busy outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      idx    <= '0;
      TX_OUT <= 1'b1;
      busy   <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      idx    <= idx_nxt;
      TX_OUT <= tx_nxt;
      busy   <= busy_nxt;
    end
  end

  // Shadow copies of the request, frozen for the whole frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      presc_q   <= '0;
    end else if (accept) begin
      data_q    <= P_DATA;
      par_en_q  <= PAR_EN;
      par_typ_q <= PAR_TYP;
      presc_q   <= (Prescale < MIN_P) ? MIN_P : Prescale;
    end
  end

endmodule
